// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt priority encoder: default sizes,
// FSM state encoding and priority-mode selectors.
package irq_pkg;

  // Default number of request sources and index width.
  localparam int IRQ_N     = 16;
  localparam int IRQ_IDX_W = 4;

  // Priority modes for the RR parameter.
  localparam int RR_FIXED = 0;  // index 0 always highest
  localparam int RR_ROUND = 1;  // rotate priority after each acked grant

  // Grant FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_BUBBLE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_pri_encoder_pri_enc.sv
// Combinational priority search: finds the first set bit of cand_i
// scanning upward from start_i and wrapping from N-1 back to 0.
// Done as rotate-right by start, lowest-set-bit, then un-rotate.
module pri_enc_n #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     cand_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] index_o
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] pos;
  logic [IDX_W:0]   sum;

  // Rotating the doubled vector puts cand_i[start_i] at bit 0.
  assign rot = N'({cand_i, cand_i} >> start_i);

  // Lowest set bit of the rotated vector; the downward loop leaves the
  // smallest index as the final assignment.
  always_comb begin
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) pos = IDX_W'(i);
    end
  end

  assign found_o = |cand_i;

  // Undo the rotation modulo N; start_i is always below N so one
  // conditional subtract is enough.
  assign sum     = {1'b0, pos} + {1'b0, start_i};
  assign index_o = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N))
                                            : sum[IDX_W-1:0];

endmodule

// File: rtl/irq_pri_encoder.sv
// Registered interrupt priority encoder. Collects sticky requests,
// picks one eligible source by fixed or round-robin priority, and holds
// the grant stable until the pipeline acks it. All outputs are flops.
module irq_pri_encoder
  import irq_pkg::*;
#(
  parameter int N     = IRQ_N,
  parameter int IDX_W = IRQ_IDX_W,
  parameter int RR    = RR_FIXED
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N-1:0]     req_in,
  input  logic [N-1:0]     mask,
  input  logic             clr_all,
  input  logic             ack,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot,
  output logic [N-1:0]     pending
);

  irq_state_e       state_q, state_d;
  logic [N-1:0]     pending_q, pending_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     onehot_q, dec_d;

  logic [N-1:0]     cand;
  logic [N-1:0]     clr_mask;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] next_ptr;
  logic             found;

  // Only already-pending requests compete; this cycle's req_in does not.
  assign cand  = pending_q & mask;
  assign start = (RR == RR_ROUND) ? ptr_q : '0;

  pri_enc_n #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pri_enc (
    .cand_i  (cand),
    .start_i (start),
    .found_o (found),
    .index_o (sel_idx)
  );

  // Pointer moves to the source just after the one being acked.
  assign next_ptr = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);

  // An ack only clears the bit it targets, and only while a grant is held.
  assign clr_mask = (valid_q && ack) ? onehot_q : '0;

  // Binary-to-one-hot decode of the next index.
  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    assign dec_d[gi] = (idx_d == IDX_W'(gi));
  end

  // Next-state logic for pending bits, grant FSM and round-robin pointer.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    // A fresh request re-pends over an ack clear; clr_all wins over both.
    pending_d = clr_all ? '0 : ((pending_q & ~clr_mask) | req_in);
    case (state_q)
      ST_IDLE: begin
        if (found && !clr_all) begin
          idx_d   = sel_idx;
          valid_d = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // The pointer advances on ack even when clr_all also fires.
        if (ack) ptr_d = next_ptr;
        if (clr_all) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else if (ack) begin
          valid_d = 1'b0;
          state_d = ST_BUBBLE;
        end
      end
      ST_BUBBLE: begin
        // One dead cycle so the acked bit is gone before reselecting.
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      ptr_q     <= '0;
      onehot_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      onehot_q  <= dec_d & {N{valid_d}};
    end
  end

  assign valid   = valid_q;
  assign idx     = idx_q;
  assign onehot  = onehot_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_irq_pri_encoder.sv
// Directed bench for irq_pri_encoder. Two instances share stimulus:
// one fixed-priority, one round-robin. Inputs change 1 ns after the
// rising edge and outputs are sampled at that same point.
module tb_irq_pri_encoder;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] req_in;
  logic [15:0] mask;
  logic        clr_all;
  logic        ack;

  logic        fp_valid, rr_valid;
  logic [3:0]  fp_idx, rr_idx;
  logic [15:0] fp_onehot, rr_onehot;
  logic [15:0] fp_pending, rr_pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  irq_pri_encoder #(.N(16), .IDX_W(4), .RR(0)) dut_fp (
    .clk     (clk),
    .resetn  (resetn),
    .req_in  (req_in),
    .mask    (mask),
    .clr_all (clr_all),
    .ack     (ack),
    .valid   (fp_valid),
    .idx     (fp_idx),
    .onehot  (fp_onehot),
    .pending (fp_pending)
  );

  irq_pri_encoder #(.N(16), .IDX_W(4), .RR(1)) dut_rr (
    .clk     (clk),
    .resetn  (resetn),
    .req_in  (req_in),
    .mask    (mask),
    .clr_all (clr_all),
    .ack     (ack),
    .valid   (rr_valid),
    .idx     (rr_idx),
    .onehot  (rr_onehot),
    .pending (rr_pending)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetn  = 1'b0;
    req_in  = '0;
    mask    = 16'hFFFF;
    clr_all = 1'b0;
    ack     = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    resetn  = 1'b0;
    req_in  = 16'hFFFF;
    mask    = 16'hFFFF;
    clr_all = 1'b0;
    ack     = 1'b0;
    repeat (3) tick();
    n_cmp++; if (fp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", fp_valid); end
    n_cmp++; if (fp_pending !== 16'h0000) begin n_bad++; $display("FAIL reset_pending: got %h want 0000", fp_pending); end
    n_cmp++; if (fp_idx !== 4'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", fp_idx); end
    n_cmp++; if (fp_onehot !== 16'h0000) begin n_bad++; $display("FAIL reset_onehot: got %h want 0000", fp_onehot); end
    resetn = 1'b1;
    tick();
    n_cmp++; if (fp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_lat1_valid: got %0b want 0", fp_valid); end
    n_cmp++; if (fp_pending !== 16'hFFFF) begin n_bad++; $display("FAIL reset_lat1_pending: got %h want ffff", fp_pending); end
    tick();
    n_cmp++; if (fp_valid !== 1'b1 || fp_idx !== 4'd0) begin n_bad++; $display("FAIL reset_first_grant: got v=%0b idx=%0d want v=1 idx=0", fp_valid, fp_idx); end
    n_cmp++; if (fp_onehot !== 16'h0001) begin n_bad++; $display("FAIL reset_first_onehot: got %h want 0001", fp_onehot); end
    $display("txn reset: first grant idx=%0d", fp_idx);
  endtask

  task automatic test_fixed;
    do_reset();
    req_in = 16'h0120;
    tick();
    req_in = '0;
    n_cmp++; if (fp_valid !== 1'b0 || fp_pending !== 16'h0120) begin n_bad++; $display("FAIL fixed_pend: got v=%0b p=%h want v=0 p=0120", fp_valid, fp_pending); end
    tick();
    n_cmp++; if (fp_valid !== 1'b1 || fp_idx !== 4'd5) begin n_bad++; $display("FAIL fixed_grant5: got v=%0b idx=%0d want v=1 idx=5", fp_valid, fp_idx); end
    n_cmp++; if (fp_onehot !== 16'h0020) begin n_bad++; $display("FAIL fixed_onehot5: got %h want 0020", fp_onehot); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++; if (fp_valid !== 1'b0 || fp_pending !== 16'h0100) begin n_bad++; $display("FAIL fixed_ack5: got v=%0b p=%h want v=0 p=0100", fp_valid, fp_pending); end
    n_cmp++; if (fp_onehot !== 16'h0000) begin n_bad++; $display("FAIL fixed_onehot_drop: got %h want 0000", fp_onehot); end
    tick();
    n_cmp++; if (fp_valid !== 1'b0) begin n_bad++; $display("FAIL fixed_bubble: got v=%0b want 0", fp_valid); end
    tick();
    n_cmp++; if (fp_valid !== 1'b1 || fp_idx !== 4'd8) begin n_bad++; $display("FAIL fixed_grant8: got v=%0b idx=%0d want v=1 idx=8", fp_valid, fp_idx); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++; if (fp_valid !== 1'b0 || fp_pending !== 16'h0000) begin n_bad++; $display("FAIL fixed_ack8: got v=%0b p=%h want v=0 p=0000", fp_valid, fp_pending); end
    repeat (3) tick();
    n_cmp++; if (fp_valid !== 1'b0) begin n_bad++; $display("FAIL fixed_quiet: got v=%0b want 0", fp_valid); end
    $display("txn fixed: grants 5 then 8");
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_seq [4];
    exp_seq[0] = 4'd0;
    exp_seq[1] = 4'd3;
    exp_seq[2] = 4'd0;
    exp_seq[3] = 4'd3;
    do_reset();
    req_in = 16'h0009;
    ack    = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (rr_valid !== 1'b1 || rr_idx !== exp_seq[k]) begin n_bad++; $display("FAIL rr_grant%0d: got v=%0b idx=%0d want v=1 idx=%0d", k, rr_valid, rr_idx, exp_seq[k]); end
      $display("txn rr: grant %0d idx=%0d", k, rr_idx);
      tick();
      n_cmp++; if (rr_valid !== 1'b0 || rr_pending !== 16'h0009) begin n_bad++; $display("FAIL rr_ack%0d: got v=%0b p=%h want v=0 p=0009", k, rr_valid, rr_pending); end
      tick();
    end
    ack    = 1'b0;
    req_in = '0;
  endtask

  task automatic test_hold_mask;
    do_reset();
    req_in = 16'h0004;
    tick();
    req_in = '0;
    tick();
    n_cmp++; if (fp_valid !== 1'b1 || fp_idx !== 4'd2) begin n_bad++; $display("FAIL hold_grant2: got v=%0b idx=%0d want v=1 idx=2", fp_valid, fp_idx); end
    mask   = 16'hFFFB;
    req_in = 16'h0002;
    tick();
    req_in = '0;
    n_cmp++; if (fp_valid !== 1'b1 || fp_idx !== 4'd2 || fp_pending !== 16'h0006) begin n_bad++; $display("FAIL hold_keep: got v=%0b idx=%0d p=%h want v=1 idx=2 p=0006", fp_valid, fp_idx, fp_pending); end
    tick();
    n_cmp++; if (fp_valid !== 1'b1 || fp_idx !== 4'd2) begin n_bad++; $display("FAIL hold_keep2: got v=%0b idx=%0d want v=1 idx=2", fp_valid, fp_idx); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_cmp++; if (fp_valid !== 1'b0 || fp_pending !== 16'h0002) begin n_bad++; $display("FAIL hold_ack: got v=%0b p=%h want v=0 p=0002", fp_valid, fp_pending); end
    repeat (2) tick();
    n_cmp++; if (fp_valid !== 1'b1 || fp_idx !== 4'd1) begin n_bad++; $display("FAIL hold_next1: got v=%0b idx=%0d want v=1 idx=1", fp_valid, fp_idx); end
    mask = 16'hFFFF;
    $display("txn hold: grant 2 held, then 1");
  endtask

  task automatic test_simultaneous;
    do_reset();
    req_in = 16'h0080;
    tick();
    req_in = '0;
    tick();
    n_cmp++; if (fp_valid !== 1'b1 || fp_idx !== 4'd7) begin n_bad++; $display("FAIL sim_grant7: got v=%0b idx=%0d want v=1 idx=7", fp_valid, fp_idx); end
    ack    = 1'b1;
    req_in = 16'h0080;
    tick();
    ack    = 1'b0;
    req_in = '0;
    n_cmp++; if (fp_valid !== 1'b0 || fp_pending !== 16'h0080) begin n_bad++; $display("FAIL sim_repend: got v=%0b p=%h want v=0 p=0080", fp_valid, fp_pending); end
    repeat (2) tick();
    n_cmp++; if (fp_valid !== 1'b1 || fp_idx !== 4'd7) begin n_bad++; $display("FAIL sim_regrant7: got v=%0b idx=%0d want v=1 idx=7", fp_valid, fp_idx); end
    $display("txn simultaneous: 7 re-granted");
  endtask

  task automatic test_clr_ack;
    do_reset();
    clr_all = 1'b1;
    req_in  = 16'h0003;
    tick();
    n_cmp++; if (fp_pending !== 16'h0000) begin n_bad++; $display("FAIL clr_beats_req: got p=%h want 0000", fp_pending); end
    clr_all = 1'b0;
    req_in  = 16'h0030;
    tick();
    req_in = '0;
    tick();
    n_cmp++; if (rr_valid !== 1'b1 || rr_idx !== 4'd4) begin n_bad++; $display("FAIL clr_rr_grant4: got v=%0b idx=%0d want v=1 idx=4", rr_valid, rr_idx); end
    clr_all = 1'b1;
    ack     = 1'b1;
    tick();
    clr_all = 1'b0;
    ack     = 1'b0;
    n_cmp++; if (rr_valid !== 1'b0 || rr_pending !== 16'h0000) begin n_bad++; $display("FAIL clr_ack_drop: got v=%0b p=%h want v=0 p=0000", rr_valid, rr_pending); end
    n_cmp++; if (fp_valid !== 1'b0 || fp_pending !== 16'h0000) begin n_bad++; $display("FAIL clr_ack_drop_fp: got v=%0b p=%h want v=0 p=0000", fp_valid, fp_pending); end
    req_in = 16'h0218;
    tick();
    req_in = '0;
    tick();
    n_cmp++; if (rr_valid !== 1'b1 || rr_idx !== 4'd9) begin n_bad++; $display("FAIL clr_ptr_adv: got v=%0b idx=%0d want v=1 idx=9", rr_valid, rr_idx); end
    n_cmp++; if (fp_valid !== 1'b1 || fp_idx !== 4'd3) begin n_bad++; $display("FAIL clr_fp_grant3: got v=%0b idx=%0d want v=1 idx=3", fp_valid, fp_idx); end
    $display("txn clr_ack: rr next idx=%0d", rr_idx);
  endtask

  task automatic test_idle_ack;
    do_reset();
    ack    = 1'b1;
    req_in = 16'h0040;
    tick();
    req_in = '0;
    n_cmp++; if (fp_valid !== 1'b0 || fp_pending !== 16'h0040) begin n_bad++; $display("FAIL idle_ack_ignored: got v=%0b p=%h want v=0 p=0040", fp_valid, fp_pending); end
    tick();
    ack = 1'b0;
    n_cmp++; if (fp_valid !== 1'b1 || fp_idx !== 4'd6) begin n_bad++; $display("FAIL idle_ack_grant6: got v=%0b idx=%0d want v=1 idx=6", fp_valid, fp_idx); end
    $display("txn idle_ack: grant idx=%0d", fp_idx);
  endtask

  task automatic test_reset_mid;
    do_reset();
    req_in = 16'h0110;
    tick();
    req_in = '0;
    tick();
    n_cmp++; if (fp_valid !== 1'b1 || fp_idx !== 4'd4) begin n_bad++; $display("FAIL mid_grant4: got v=%0b idx=%0d want v=1 idx=4", fp_valid, fp_idx); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    n_cmp++; if (fp_valid !== 1'b0 || fp_idx !== 4'd0 || fp_onehot !== 16'h0000 || fp_pending !== 16'h0000) begin n_bad++; $display("FAIL mid_reset_outs: got v=%0b idx=%0d oh=%h p=%h want all 0", fp_valid, fp_idx, fp_onehot, fp_pending); end
    repeat (2) tick();
    n_cmp++; if (fp_valid !== 1'b0 || fp_pending !== 16'h0000) begin n_bad++; $display("FAIL mid_no_residual: got v=%0b p=%h want v=0 p=0000", fp_valid, fp_pending); end
    $display("txn reset_mid: grant dropped");
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_hold_mask();
    test_simultaneous();
    test_clr_ack();
    test_idle_ack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
